div_clk_monitor: RTL
====================

Name: div_clk_monitor

Overview:
- Sits directly downstream of the even-ratio clock divider (div2/div4/div6 outputs).
- Checks one selected divided output against its expected even ratio N, all in the clk domain.
- Reports lock, edge pulses, measured high/low run lengths and sticky error flags.
- Used for bring-up and runtime health checking of divider outputs before they drive downstream enables.

Parameters:
CNT_W, 8, width of run-length counters and cfg_ratio; run counters saturate at 2^CNT_W-1
LOCK_PERIODS, 4, consecutive good full periods (2*LOCK_PERIODS good half-periods) required to assert lock
ERRCNT_W, 8, width of the saturating error event counter

Ports:
clk  in  1  system clock, same clock as the divider
resetn  in  1  asynchronous active-low reset
en  in  1  monitor enable; low forces IDLE
cfg_ratio  in  CNT_W  expected divide ratio N; must be even and >=2; static while en=1
clr_err  in  1  single-cycle pulse, clears sticky flags and err_count
div_in  in  1  divided signal under test, synchronous to clk
rise_pulse  out  1  1-cycle pulse on the cycle div_in is first seen high
fall_pulse  out  1  1-cycle pulse on the cycle div_in is first seen low
meas_high  out  CNT_W  length of last completed high run, in clk cycles
meas_low  out  CNT_W  length of last completed low run, in clk cycles
lock  out  1  divider output verified stable
cfg_err  out  1  en=1 with cfg_ratio odd or 0
err_high  out  1  sticky: a high run differed from N/2
err_low  out  1  sticky: a low run differed from N/2
err_count  out  ERRCNT_W  saturating count of error events

Behaviour:
- Reset values: all outputs 0. Internal state: d_q=0, run_cnt=0, good_cnt=0, state=IDLE.
- Edge detection:
  - d_q is div_in registered.
  - rise = div_in & ~d_q; fall = ~div_in & d_q.
  - rise_pulse and fall_pulse are combinational from rise/fall in every state except IDLE.
- Run counter (every cycle, all states except IDLE):
  - On an edge: completed run = run_cnt; run_cnt <= 1.
  - Otherwise: run_cnt <= run_cnt+1, saturating.
  - On fall: meas_high <= run_cnt. On rise: meas_low <= run_cnt. Both registered.
- half = cfg_ratio>>1.
- State machine:
  - IDLE:
    - Entered on reset, on en=0, or on an invalid cfg.
    - Holds run_cnt=0, good_cnt=0, lock=0.
    - cfg_err = en & (cfg_ratio==0 | cfg_ratio[0]).
    - Go to ACQUIRE when en=1 and cfg is valid.
  - ACQUIRE:
    - Discards measurements (the first low run is partial).
    - Go to MEASURE on the first rise.
  - MEASURE and LOCKED, check each completed run:
    - Fall with run_cnt!=half sets err_high.
    - Rise with run_cnt!=half sets err_low.
    - Overrun: no edge and run_cnt+1 > half. Set err_high if d_q=1, else err_low, immediately without waiting for the next edge.
    - A good edge increments good_cnt.
    - MEASURE -> LOCKED when good_cnt reaches 2*LOCK_PERIODS. lock is registered and asserts the cycle after that edge.
  - Any error event:
    - err_count +1 (saturating), good_cnt=0, lock=0, state -> ACQUIRE.
    - Only one error event per cycle.
- en low in any state: IDLE next cycle. Sticky flags and err_count are retained.
- clr_err clears err_high, err_low and err_count next cycle. If clr_err coincides with a new error, the error wins: flag=1, err_count=1.
- Flags are sticky across lock re-acquisition.
- N=2 (div2): half=1. Every cycle is an edge, and a missing toggle is an immediate overrun.
- Asynchronous reset mid-operation returns everything to reset values with no pulse glitching (outputs are registered or gated by state).

Decomposition:
- Package div_mon_pkg holds:
  - state enum {IDLE, ACQUIRE, MEASURE, LOCKED}
  - default CNT_W
  - localparam LOCK_HALVES = 2*LOCK_PERIODS (helper function)
- One sub-module, div_edge_meas, containing the d_q register, edge detection and the saturating run counter. It outputs rise, fall, run_cnt.
- The top level holds the FSM, the checks and the flags.

Test Plan:
- N=4, clean div4 pattern (2 high/2 low), en at cycle 0. Required: meas_high=meas_low=2; no error flags; lock rises the cycle after the 8th good edge following the first rise.
- N=6, div6 pattern with one high run stretched to 4 cycles. Required: err_high=1 on the overrun cycle (4th high cycle); err_count=1; lock=0; relock after 8 further good edges.
- N=2, div_in stuck at 0 after lock. Required: err_low=1 and lock=0 on the 2nd low cycle; err_count increments once per re-acquire attempt only after a rise.
- cfg_ratio=5 with en=1. Required: cfg_err=1, state stays IDLE, no pulses, lock=0. Changing to 4 clears cfg_err and starts ACQUIRE.
- clr_err pulsed on the same cycle as a low-run error. Required: err_low=1, err_count=1. Then clr_err alone gives flags 0, count 0.
- resetn asserted asynchronously mid-LOCKED. Required: all outputs 0 immediately. After release: ACQUIRE, and lock again after 8 good edges.

Source files
------------

// File: rtl/div_mon_pkg.sv
// rtl/div_mon_pkg.sv - shared types and constants for the divided-clock monitor
package div_mon_pkg;

  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } mon_state_t;

  // Lock is counted in half-periods: each good full period yields two good edges.
  function automatic int lock_halves(input int lock_periods);
    return 2 * lock_periods;
  endfunction

endpackage

// File: rtl/div_edge_meas.sv
// rtl/div_edge_meas.sv - edge detector and saturating run-length counter for div_in
module div_edge_meas
  import div_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_hold,
  input  logic             i_div,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_run_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             r_d_q;
  logic [CNT_W-1:0] r_run_cnt;

  assign o_rise    = i_div & ~r_d_q;
  assign o_fall    = ~i_div & r_d_q;
  assign o_run_cnt = r_run_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_d_q     <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_d_q <= i_div;
      if (i_hold) begin
        r_run_cnt <= '0;
      end else if (o_rise || o_fall) begin
        r_run_cnt <= ONE;
      end else if (r_run_cnt != '1) begin
        r_run_cnt <= r_run_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - checks one even-ratio divider output for correct high/low runs
// and reports lock, edge pulses, measured run lengths and sticky error flags.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LOCK_PERIODS = 4,
  parameter int ERRCNT_W     = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic [CNT_W-1:0]    cfg_ratio,
  input  logic                clr_err,
  input  logic                div_in,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [CNT_W-1:0]    meas_high,
  output logic [CNT_W-1:0]    meas_low,
  output logic                lock,
  output logic                cfg_err,
  output logic                err_high,
  output logic                err_low,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int LOCK_HALVES = lock_halves(LOCK_PERIODS);
  localparam int GW          = $clog2(LOCK_HALVES + 1);
  localparam logic [GW-1:0]       GOOD_MAX = GW'(LOCK_HALVES);
  localparam logic [GW-1:0]       GOOD_ONE = GW'(1);
  localparam logic [ERRCNT_W-1:0] ERR_ONE  = ERRCNT_W'(1);
  localparam logic [CNT_W:0]      RUN_ONE  = (CNT_W + 1)'(1);

  mon_state_t          r_state, w_state_nxt;
  logic [GW-1:0]       r_good_cnt;
  logic [CNT_W-1:0]    r_meas_high, r_meas_low;
  logic [ERRCNT_W-1:0] r_err_count;
  logic                r_lock, r_cfg_err, r_err_high, r_err_low;

  logic             w_rise, w_fall, w_edge, w_cfg_ok, w_chk, w_over;
  logic             w_err_hi, w_err_lo, w_err, w_good;
  logic [CNT_W-1:0] w_run_cnt, w_half;
  logic [CNT_W:0]   w_run_p1;
  logic [GW-1:0]    w_good_inc;

  div_edge_meas #(.CNT_W(CNT_W)) u_edge_meas (
    .clk       (clk),
    .resetn    (resetn),
    .i_hold    (r_state == IDLE),
    .i_div     (div_in),
    .o_rise    (w_rise),
    .o_fall    (w_fall),
    .o_run_cnt (w_run_cnt)
  );

  assign w_edge     = w_rise | w_fall;
  assign w_cfg_ok   = (cfg_ratio != '0) && !cfg_ratio[0];
  assign w_half     = cfg_ratio >> 1;
  assign w_chk      = en && w_cfg_ok && ((r_state == MEASURE) || (r_state == LOCKED));
  assign w_run_p1   = {1'b0, w_run_cnt} + RUN_ONE;
  assign w_over     = !w_edge && (w_run_p1 > {1'b0, w_half});
  // Without an edge div_in equals its registered copy, so it tells which run is overlong.
  assign w_err_hi   = w_chk && ((w_fall && (w_run_cnt != w_half)) || (w_over && div_in));
  assign w_err_lo   = w_chk && ((w_rise && (w_run_cnt != w_half)) || (w_over && !div_in));
  assign w_err      = w_err_hi | w_err_lo;
  assign w_good     = w_chk && w_edge && (w_run_cnt == w_half);
  assign w_good_inc = r_good_cnt + GOOD_ONE;

  assign rise_pulse = w_rise && (r_state != IDLE);
  assign fall_pulse = w_fall && (r_state != IDLE);
  assign meas_high  = r_meas_high;
  assign meas_low   = r_meas_low;
  assign lock       = r_lock;
  assign cfg_err    = r_cfg_err;
  assign err_high   = r_err_high;
  assign err_low    = r_err_low;
  assign err_count  = r_err_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en && w_cfg_ok) w_state_nxt = ACQUIRE;
      ACQUIRE: if (w_rise) w_state_nxt = MEASURE;
      MEASURE: begin
        if (w_err) w_state_nxt = ACQUIRE;
        else if (w_good && (w_good_inc == GOOD_MAX)) w_state_nxt = LOCKED;
      end
      LOCKED:  if (w_err) w_state_nxt = ACQUIRE;
      default: w_state_nxt = IDLE;
    endcase
    if (!en || !w_cfg_ok) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_good_cnt  <= '0;
      r_lock      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_meas_high <= '0;
      r_meas_low  <= '0;
      r_err_high  <= 1'b0;
      r_err_low   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock    <= (w_state_nxt == LOCKED);
      r_cfg_err <= en && !w_cfg_ok;

      if ((w_state_nxt == IDLE) || w_err) r_good_cnt <= '0;
      else if (w_good && (r_good_cnt != GOOD_MAX)) r_good_cnt <= w_good_inc;

      if (w_chk && w_fall) r_meas_high <= w_run_cnt;
      if (w_chk && w_rise) r_meas_low  <= w_run_cnt;

      // A new error outranks a simultaneous clear.
      if (w_err_hi) r_err_high <= 1'b1;
      else if (clr_err) r_err_high <= 1'b0;
      if (w_err_lo) r_err_low <= 1'b1;
      else if (clr_err) r_err_low <= 1'b0;

      if (w_err) begin
        if (clr_err) r_err_count <= ERR_ONE;
        else if (r_err_count != '1) r_err_count <= r_err_count + ERR_ONE;
      end else if (clr_err) begin
        r_err_count <= '0;
      end
    end
  end

endmodule
